// File: rtl/seed_lfsr_pkg.sv
// Shared types and reference tap masks for the seed_lfsr generator.
package seed_lfsr_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Maximal-length Galois feedback masks
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR iteration: shift right, fold TAPS in on a shifted-out 1.
module lfsr_step #(
    parameter int unsigned      WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(64'hD800_0000_0000_0000)
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = (din >> 1) ^ (din[0] ? TAPS : '0);

endmodule

// File: rtl/seed_lfsr.sv
// Seedable Galois LFSR streaming its state over valid/ready, advancing STEPS iterations per
// accepted word; flags zero-seed substitution and return to the loaded seed.
module seed_lfsr
    import seed_lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 64,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_64),
    parameter int unsigned      STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(64'h1),
    parameter int unsigned      COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   shift_seed,
    output logic               seed_fixed,
    output logic               period_done,
    output logic [COUNT_W-1:0] step_count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   stored_q, stored_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               fixed_q, fixed_d;
    logic               done_q, done_d;
    logic               advance;

    // STEPS single-step stages chained; chain[STEPS] is the advanced state
    logic [WIDTH-1:0] chain [STEPS+1];
    assign chain[0] = shift_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .din  (chain[g]),
            .dout (chain[g+1])
        );
    end

    // In RUN the word is always valid, so the handshake reduces to out_ready
    assign advance = (state_q == RUN) && out_ready && en && !load;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        stored_d = stored_q;
        count_d  = count_q;
        fixed_d  = 1'b0;
        done_d   = 1'b0;
        if (load) begin
            state_d  = RUN;
            shift_d  = (seed == '0) ? DEFAULT_SEED : seed;
            stored_d = shift_d;
            count_d  = '0;
            fixed_d  = (seed == '0);
        end else if (advance) begin
            shift_d = chain[STEPS];
            count_d = count_q + COUNT_W'(1);
            done_d  = (chain[STEPS] == stored_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            shift_q  <= '0;
            stored_q <= '0;
            count_q  <= '0;
            fixed_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            stored_q <= stored_d;
            count_q  <= count_d;
            fixed_q  <= fixed_d;
            done_q   <= done_d;
        end
    end

    assign out_valid   = (state_q == RUN);
    assign shift_seed  = shift_q;
    assign seed_fixed  = fixed_q;
    assign period_done = done_q;
    assign step_count  = count_q;

endmodule

// File: tb/tb_seed_lfsr.sv
// Bench for seed_lfsr: 8-bit instances with STEPS=1 and STEPS=2 on shared stimulus,
// directed sequences plus random traffic against a transaction-level reference model.
module tb_seed_lfsr;

    logic        clk;
    logic        reset;
    logic        load;
    logic [7:0]  seed;
    logic        en;
    logic        out_ready;

    logic        valid_s [2];
    logic [7:0]  shift_s [2];
    logic        fixed_s [2];
    logic        pd_s    [2];
    logic [31:0] cnt_s   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance
    logic [7:0]  m_st     [2];
    logic [7:0]  m_stored [2];
    logic [31:0] m_cnt    [2];
    bit          m_run    [2];
    bit          m_fix    [2];
    bit          m_pd     [2];

    seed_lfsr #(
        .WIDTH        (8),
        .TAPS         (8'hB8),
        .STEPS        (1),
        .DEFAULT_SEED (8'h01),
        .COUNT_W      (32)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .seed        (seed),
        .en          (en),
        .out_ready   (out_ready),
        .out_valid   (valid_s[0]),
        .shift_seed  (shift_s[0]),
        .seed_fixed  (fixed_s[0]),
        .period_done (pd_s[0]),
        .step_count  (cnt_s[0])
    );

    seed_lfsr #(
        .WIDTH        (8),
        .TAPS         (8'hB8),
        .STEPS        (2),
        .DEFAULT_SEED (8'h01),
        .COUNT_W      (32)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .seed        (seed),
        .en          (en),
        .out_ready   (out_ready),
        .out_valid   (valid_s[1]),
        .shift_seed  (shift_s[1]),
        .seed_fixed  (fixed_s[1]),
        .period_done (pd_s[1]),
        .step_count  (cnt_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n Galois iterations of the x^8+x^6+x^5+x^4+1 register, written as plain arithmetic
    function automatic logic [7:0] ref_adv(input logic [7:0] v, input int n);
        int unsigned x;
        x = v;
        for (int i = 0; i < n; i++) begin
            if (x % 2 == 1) x = (x / 2) ^ 'hB8;
            else            x = x / 2;
        end
        return x[7:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = '0; m_stored[k] = '0; m_cnt[k] = '0;
            m_run[k] = 0; m_fix[k] = 0; m_pd[k] = 0;
        end
    endtask

    // Transaction-level update for one clock edge using the inputs presented at that edge
    task automatic model_edge();
        bit fire;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            fire     = m_run[k] && out_ready && en && !load;
            m_fix[k] = 0;
            m_pd[k]  = 0;
            if (load) begin
                m_st[k]     = (seed == 8'h00) ? 8'h01 : seed;
                m_stored[k] = m_st[k];
                m_cnt[k]    = 0;
                m_fix[k]    = (seed == 8'h00);
                m_run[k]    = 1;
            end else if (fire) begin
                m_st[k]  = ref_adv(m_st[k], k + 1);
                m_cnt[k] = m_cnt[k] + 1;
                m_pd[k]  = (m_st[k] == m_stored[k]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s[%0d].shift_seed", tag, k), 64'(shift_s[k]), 64'(m_st[k]));
            check($sformatf("%s[%0d].out_valid", tag, k), 64'(valid_s[k]), 64'(m_run[k]));
            check($sformatf("%s[%0d].seed_fixed", tag, k), 64'(fixed_s[k]), 64'(m_fix[k]));
            check($sformatf("%s[%0d].period_done", tag, k), 64'(pd_s[k]), 64'(m_pd[k]));
            check($sformatf("%s[%0d].step_count", tag, k), 64'(cnt_s[k]), 64'(m_cnt[k]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [7:0] exp_seq [6];
    int         pulses;

    initial begin
        exp_seq[0] = 8'h01; exp_seq[1] = 8'hB8; exp_seq[2] = 8'h5C;
        exp_seq[3] = 8'h2E; exp_seq[4] = 8'h17; exp_seq[5] = 8'hB3;

        reset = 1'b1; load = 1'b0; seed = '0; en = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Basic sequence, STEPS=1 and STEPS=2 side by side
        load = 1'b1; seed = 8'h01; en = 1'b1; out_ready = 1'b1;
        tick("seq");
        load = 1'b0;
        check("seq.word0", 64'(shift_s[0]), 64'(exp_seq[0]));
        for (int i = 1; i < 6; i++) begin
            tick("seq");
            check($sformatf("seq.word%0d", i), 64'(shift_s[0]), 64'(exp_seq[i]));
            check($sformatf("seq.count%0d", i), 64'(cnt_s[0]), 64'(i));
            if (i == 1) begin
                check("steps2.word", 64'(shift_s[1]), 64'h5C);
                check("steps2.count", 64'(cnt_s[1]), 64'd1);
            end
        end

        // Zero seed substitution
        load = 1'b1; seed = 8'h00; out_ready = 1'b0;
        tick("zero");
        check("zero.fixed", 64'(fixed_s[0]), 64'd1);
        check("zero.word", 64'(shift_s[0]), 64'h01);
        load = 1'b0;
        tick("zero_after");
        check("zero.fixed_clear", 64'(fixed_s[0]), 64'd0);

        // Full period
        load = 1'b1; seed = 8'h01; out_ready = 1'b1; en = 1'b1;
        tick("period_load");
        load = 1'b0;
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            tick("period");
            if (pd_s[0]) pulses++;
        end
        check("period.word", 64'(shift_s[0]), 64'h01);
        check("period.count", 64'(cnt_s[0]), 64'd255);
        check("period.pulses", 64'(pulses), 64'd1);
        check("period.pd_last", 64'(pd_s[0]), 64'd1);

        // Back-pressure, then en=0, then load beating a handshake
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick("bp");
        check("bp.word", 64'(shift_s[0]), 64'h01);
        check("bp.count", 64'(cnt_s[0]), 64'd255);
        out_ready = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold.word", 64'(shift_s[0]), 64'h01);
        check("hold.count", 64'(cnt_s[0]), 64'd255);
        en = 1'b1; load = 1'b1; seed = 8'h5A;
        tick("reload");
        load = 1'b0;
        check("reload.word", 64'(shift_s[0]), 64'h5A);
        check("reload.count", 64'(cnt_s[0]), 64'd0);
        tick("run");
        tick("run");

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("areset.valid", 64'(valid_s[0]), 64'd0);
        check("areset.word", 64'(shift_s[0]), 64'h00);
        check_all("areset");
        out_ready = 1'b1;
        tick("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready = (i % 2 == 0);
            tick("empty");
        end
        check("empty.valid", 64'(valid_s[0]), 64'd0);

        // Random traffic
        load = 1'b1; seed = 8'($urandom);
        tick("rand_load");
        for (int i = 0; i < 600; i++) begin
            load      = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seed_lfsr.md
Name: seed_lfsr

Overview:
Parametrised pseudo-random seed generator; successor to the plain seed pipeline flop. Holds a WIDTH-bit Galois LFSR state that can be loaded with a seed and advanced STEPS positions per accepted output word. Streams state words to consumers (pattern generators, game-board initialisers) over a valid/ready handshake. Flags zero-seed substitution and full-period completion.

Parameters:
WIDTH, 64, LFSR state width in bits (>=4)
TAPS, 64'hD800_0000_0000_0000, Galois feedback mask XORed in when the shifted-out bit is 1
STEPS, 1, LFSR iterations applied per advance (1..WIDTH)
DEFAULT_SEED, 64'h1, nonzero value substituted for an all-zero seed
COUNT_W, 32, width of the advance counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
load  input  1  load seed this cycle
seed  input  WIDTH  seed value, sampled when load=1
en  input  1  enables advancing; when 0, state holds even if handshake fires
out_ready  input  1  consumer accepts shift_seed
out_valid  output  1  shift_seed holds a valid word
shift_seed  output  WIDTH  current LFSR state
seed_fixed  output  1  one-cycle pulse: zero seed was replaced by DEFAULT_SEED
period_done  output  1  one-cycle pulse: state returned to the loaded seed
step_count  output  COUNT_W  advances since last load, wraps modulo 2^COUNT_W

Behaviour:
- Reset (async, active-high): state EMPTY; shift_seed=0, out_valid=0, seed_fixed=0, period_done=0, step_count=0, stored seed=0. Deassertion is synchronous to clk.
- States: EMPTY (no seed loaded), RUN. EMPTY->RUN on load; RUN->RUN on load (reseed). No RUN->EMPTY transition except reset.
- Load: on edge with load=1, next cycle shift_seed=seed (or DEFAULT_SEED if seed==0, with seed_fixed=1 for that one cycle), out_valid=1, step_count=0, stored seed = the value actually loaded. Latency 1 cycle.
- Single step: lsb=s[0]; s'=(s>>1) ^ (lsb ? TAPS : 0). Advance = STEPS chained steps, computed combinationally within one cycle.
- Advance fires when state=RUN, out_valid=1, out_ready=1, en=1, and load=0. Next cycle: shift_seed=advanced value, step_count+=1 (wraps), out_valid remains 1.
- Handshake with en=0: word is still consumed, but shift_seed and step_count hold. The consumer sees the same word again.
- In EMPTY, out_valid=0; out_ready is ignored; shift_seed stays 0.
- load and advance in the same cycle: load wins; the word presented that cycle counts as consumed; the next word is the new seed.
- period_done: pulses for one cycle in the cycle after an advance whose result equals the stored seed. step_count is not cleared.
- Register output: shift_seed is never combinational from inputs.
- Reset mid-stream: all outputs return to reset values immediately; a load is required before the next word.

Decomposition:
- Package seed_lfsr_pkg: state enum {EMPTY, RUN}; maximal-length TAPS constants for widths 8/16/32/64 (8'hB8, 16'hB400, 32'h8020_0003, 64'hD800_0000_0000_0000).
- Sub-module lfsr_step: purely combinational single Galois step, parameters WIDTH and TAPS. Instantiate it STEPS times in a generate chain.
- Top-level seed_lfsr holds the FSM, state register, stored seed, counter and pulse flops.

Test Plan:
- WIDTH=8, TAPS=8'hB8, STEPS=1: reset, load seed=8'h01, hold out_ready=1, en=1 -> shift_seed sequence 01, B8, 5C, 2E, 17, B3; step_count 0..5.
- Same configuration with STEPS=2: load 8'h01, then one handshake -> shift_seed=8'h5C, step_count=1.
- Load seed=8'h00 -> next cycle shift_seed=DEFAULT_SEED (8'h01), seed_fixed=1 for exactly one cycle, out_valid=1.
- Load 8'h01, run 255 handshakes -> shift_seed=8'h01, period_done pulses exactly once after advance 255, step_count=255.
- Back-pressure: out_ready=0 for 5 cycles -> shift_seed and step_count stable. Then en=0 with out_ready=1 -> word repeats. Then load=1 together with out_ready=1 -> new seed appears, step_count=0.
- Assert reset mid-stream (asynchronously, between clock edges) -> out_valid=0 and shift_seed=0 immediately; out_ready pulses while EMPTY have no effect.
